pipelined_cla_adder: RTL and testbench
======================================

// Module: pipelined_cla_adder
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder; successor to the fixed 4-bit CLA.
//  WIDTH-bit operands are split into STAGES equal slices.
//  - Each slice is added in its own pipeline stage using GROUP-bit CLA groups
//    with a second-level group-carry lookahead.
//  - The inter-slice carry is registered between stages.
//  Valid/ready streaming on input and output; one sum per clock at full throughput.
// PARAMETERS
//  WIDTH   32  operand/sum width in bits
//  GROUP    4  bits per first-level lookahead group
//  STAGES   2  pipeline register stages (= latency); WIDTH % (GROUP*STAGES) must be 0
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active low
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry in (ignored when sub=1)
//  sub        in   1      1 = a - b (only with PIPE_CLA_SUB_EN)
//  out_valid  out  1      result beat valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  a + b + c_in (or a - b)
//  c_out      out  1      carry out of MSB (inverted borrow in sub mode)
//  ovf        out  1      signed overflow = carry-into-MSB ^ c_out
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all stage valid bits, out_valid, sum, c_out and ovf are 0.
//    in_ready is 1 in the first cycle after reset.
//  - Reset mid-operation flushes every in-flight beat. None are delivered later.
//  - Accept: the beat transfers on a posedge where in_valid & in_ready.
//  - Stage k (0..STAGES-1) holds: valid bit; sum bits of slices 0..k; registered
//    carry out of slice k; unprocessed a/b bits of slices k+1..STAGES-1.
//  - Stage 0 computes slice 0 from a, b and c_in. Stage k computes slice k using
//    the carry registered by stage k-1.
//  - Slice arithmetic: g=a&b, p=a^b per bit; group G/P per GROUP bits; group carries
//    by lookahead; sum = p ^ carry. Result bit-exact to the WIDTH+1-bit sum a+b+c_in.
//  - Latency: a beat accepted on edge N is presented with out_valid=1 after edge
//    N+STAGES-1, i.e. STAGES clocks.
//  - Outputs come directly from the last stage register, with no combinational
//    path from inputs.
//  - Flow control, per stage: stage k loads when it is empty or its contents move on
//    this edge. The last stage moves on when out_ready=1. Bubbles collapse.
//  - in_ready = !v[0] | stage-0 moves on. Combinational from out_ready through the
//    chain of valid bits.
//  - out_valid stays high and sum/c_out/ovf hold stable while out_ready=0.
//  - Simultaneous accept and output handshake at full occupancy: both happen and
//    occupancy is unchanged.
//  - No beat is dropped or duplicated; results leave in acceptance order.
//  - Full: STAGES beats held with out_ready=0 -> in_ready=0.
//  - Empty: out_valid=0; sum/c_out/ovf hold their last delivered values.
//  - Wrap-around: sum is modulo 2^WIDTH; the extra bit goes to c_out.
// CONFIGURATION
//  PIPE_CLA_SUB_EN defined:
//    - Port sub exists and is captured with the beat.
//    - sub=1: B is replaced by ~b and carry-in is forced to 1 (c_in ignored).
//    - c_out=1 means no borrow. ovf flags signed overflow of a-b.
//  PIPE_CLA_SUB_EN undefined:
//    - No sub port and no inversion logic; add only.
// TESTING (WIDTH=16, GROUP=4, STAGES=2, out_ready=1 unless stated)
//  1. a=0xFFFF b=0x0001 c_in=0 -> 2 clocks later sum=0x0000 c_out=1 ovf=0.
//  2. a=0x7FFF b=0x0001 c_in=0 -> sum=0x8000 c_out=0 ovf=1.
//     Carry crosses the slice boundary.
//  3. Back-to-back stream of 8 random beats, in_valid always 1 -> in_ready always 1.
//     One result per clock, in order, all match the reference sum.
//  4. Stream beats; hold out_ready=0 for 3 clocks:
//     - in_ready=0 once 2 beats are held; output is stable.
//     - Release: no loss or duplication, order preserved.
//  5. Two beats in flight, rst_n=0 for 1 clock:
//     - out_valid=0 and sum=0 after that edge; in_ready=1.
//     - No stale result appears afterwards.
//  6. (PIPE_CLA_SUB_EN) a=0x0005 b=0x0007 sub=1 c_in=1 -> sum=0xFFFE c_out=0 ovf=0.
//     Next beat: a=0x8000 b=0x0001 sub=1 -> sum=0x7FFF c_out=1 ovf=1.

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: WIDTH-bit operands split into STAGES slices, one slice per stage.
// Optional subtract mode is compiled in with `define PIPE_CLA_SUB_EN.

module pipelined_cla_slice #(
  parameter int W = 16,
  parameter int G = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);
  localparam int NG = W / G;

  logic [W-1:0]  g, p, c;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   cg;
  logic          t;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    cg = '0;
    c  = '0;
    t  = 1'b0;
    // first level: group generate/propagate as flat sum-of-products
    for (int j = 0; j < NG; j++) begin
      gp[j] = 1'b1;
      for (int i = 0; i < G; i++) begin
        gp[j] = gp[j] & p[j*G+i];
        t = g[j*G+i];
        for (int m = i + 1; m < G; m++) t = t & p[j*G+m];
        gg[j] = gg[j] | t;
      end
    end
    // second level: every group carry directly from c_in and group G/P
    for (int j = 0; j <= NG; j++) begin
      cg[j] = c_in;
      for (int m = 0; m < j; m++) cg[j] = cg[j] & gp[m];
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        cg[j] = cg[j] | t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < G; i++) begin
        c[j*G+i] = cg[j];
        for (int m = 0; m < i; m++) c[j*G+i] = c[j*G+i] & p[j*G+m];
        for (int l = 0; l < i; l++) begin
          t = g[j*G+l];
          for (int m = l + 1; m < i; m++) t = t & p[j*G+m];
          c[j*G+i] = c[j*G+i] | t;
        end
      end
    end
  end

  assign sum   = p ^ c;
  assign c_out = cg[NG];
endmodule

module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef PIPE_CLA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);
  localparam int SW = WIDTH / STAGES;

  if (WIDTH % (GROUP * STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a multiple of GROUP*STAGES");
  end

  logic [STAGES-1:0] vld_pipe, up_vld, take;
  logic [STAGES:0]   ld;
  logic [WIDTH-1:0]  b_eff;
  logic              c_eff;

`ifdef PIPE_CLA_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub | c_in;
`else
  assign b_eff = b;
  assign c_eff = c_in;
`endif

  // ld[k]: stage k captures this edge; ld[STAGES] stands in for the downstream sink
  always_comb begin
    ld         = '0;
    up_vld     = '0;
    ld[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) ld[k] = ~vld_pipe[k] | ld[k+1];
    up_vld[0] = in_valid;
    for (int k = 1; k < STAGES; k++) up_vld[k] = vld_pipe[k-1];
    take = ld[STAGES-1:0] & up_vld;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) vld_pipe <= '0;
    else
      for (int k = 0; k < STAGES; k++)
        if (ld[k]) vld_pipe[k] <= up_vld[k];
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int PEND = WIDTH - k * SW;

    logic [PEND-1:0]       op_a, op_b;
    logic                  op_c;
    logic [(k+1)*SW-1:0]   sum_d, sum_r;
    logic [SW-1:0]         s_sum;
    logic                  s_co, cy_r;

    if (k == 0) begin : g_src
      assign op_a  = a;
      assign op_b  = b_eff;
      assign op_c  = c_eff;
      assign sum_d = s_sum;
    end else begin : g_src
      assign op_a  = g_st[k-1].g_ops.a_r;
      assign op_b  = g_st[k-1].g_ops.b_r;
      assign op_c  = g_st[k-1].cy_r;
      assign sum_d = {s_sum, g_st[k-1].sum_r};
    end

    pipelined_cla_slice #(.W(SW), .G(GROUP)) u_slice (
      .a    (op_a[SW-1:0]),
      .b    (op_b[SW-1:0]),
      .c_in (op_c),
      .sum  (s_sum),
      .c_out(s_co)
    );

    // data only moves with a valid beat so an empty stage keeps its last result
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sum_r <= '0;
        cy_r  <= 1'b0;
      end else if (take[k]) begin
        sum_r <= sum_d;
        cy_r  <= s_co;
      end
    end

    if (PEND > SW) begin : g_ops
      logic [PEND-SW-1:0] a_r, b_r;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_r <= '0;
          b_r <= '0;
        end else if (take[k]) begin
          a_r <= op_a[PEND-1:SW];
          b_r <= op_b[PEND-1:SW];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf_r;
      // a^b^sum at the MSB recovers the carry into the MSB
      always_ff @(posedge clk) begin
        if (!rst_n)       ovf_r <= 1'b0;
        else if (take[k]) ovf_r <= op_a[SW-1] ^ op_b[SW-1] ^ s_sum[SW-1] ^ s_co;
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld_pipe[STAGES-1];
  assign sum       = g_st[STAGES-1].sum_r;
  assign c_out     = g_st[STAGES-1].cy_r;
  assign ovf       = g_st[STAGES-1].g_last.ovf_r;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector bench for pipelined_cla_adder (WIDTH=16, GROUP=4, STAGES=2).
module tb_pipelined_cla_adder;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf;
  logic [15:0] a, b, sum;
`ifdef PIPE_CLA_SUB_EN
  logic        sub = 1'b0;
`endif
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef PIPE_CLA_SUB_EN
    .sub      (sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .ovf      (ovf)
  );

  // back-to-back beats, expected {c_out, ovf, sum}
  localparam logic [15:0] BA [8] = '{16'h0001, 16'h00FF, 16'hFFFF, 16'h4000,
                                     16'h1234, 16'hABCD, 16'h8001, 16'h0F0F};
  localparam logic [15:0] BB [8] = '{16'h0002, 16'h0001, 16'hFFFF, 16'h4000,
                                     16'h4321, 16'h1111, 16'hFFFF, 16'hF0F0};
  localparam logic        BC [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam logic [17:0] BE [8] = '{18'h00003, 18'h00100, 18'h2FFFF, 18'h18000,
                                     18'h05555, 18'h0BCDE, 18'h28000, 18'h20000};

  // stall beats
  localparam logic [15:0] SA [4] = '{16'h1111, 16'hFFF0, 16'h7000, 16'h00FF};
  localparam logic [15:0] SB [4] = '{16'h2222, 16'h0020, 16'h1000, 16'h00FF};
  localparam logic        SC [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [17:0] SE [4] = '{18'h03333, 18'h20010, 18'h18001, 18'h001FE};

  // stall script per step: in_valid, beat, out_ready, expected in_ready/out_valid/result beat
  localparam logic SIV [9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
  localparam int   SBI [9] = '{0, 1, 2, 2, 2, 3, 0, 0, 0};
  localparam logic SOR [9] = '{1, 0, 0, 0, 1, 1, 1, 1, 1};
  localparam logic SIR [9] = '{1, 1, 0, 0, 1, 1, 1, 1, 1};
  localparam logic SOV [9] = '{0, 0, 1, 1, 1, 1, 1, 1, 0};
  localparam int   SOI [9] = '{-1, -1, 0, 0, 0, 1, 2, 3, 3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0;
    tick(); tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_vec++;
    if ({c_out, ovf, sum} !== 18'h0) begin n_err++; $display("FAIL reset_result: got %h want 00000", {c_out, ovf, sum}); end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add(input string name, input logic [15:0] aa, input logic [15:0] bb,
                          input logic cc, input logic [17:0] exp);
    a = aa; b = bb; c_in = cc; in_valid = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL %s_in_ready: got %b want 1", name, in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_early: out_valid got %b want 0", name, out_valid); end
    tick();
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL %s_valid: got %b want 1", name, out_valid); end
    n_vec++;
    if ({c_out, ovf, sum} !== exp) begin n_err++; $display("FAIL %s_result: got %h want %h", name, {c_out, ovf, sum}, exp); end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL %s_dup: out_valid got %b want 0", name, out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        a = BA[i]; b = BB[i]; c_in = BC[i]; in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (i < 8) begin
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      end
      tick();
      n_vec++;
      if (out_valid !== (i != 0)) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, out_valid, i != 0); end
      if (i > 0) begin
        n_vec++;
        if ({c_out, ovf, sum} !== BE[i-1]) begin
          n_err++; $display("FAIL b2b_result[%0d]: got %h want %h", i - 1, {c_out, ovf, sum}, BE[i-1]);
        end
      end
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_stall();
    for (int s = 0; s < 9; s++) begin
      in_valid  = SIV[s];
      out_ready = SOR[s];
      a = SA[SBI[s]]; b = SB[SBI[s]]; c_in = SC[SBI[s]];
      #1;
      n_vec++;
      if (in_ready !== SIR[s]) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want %b", s, in_ready, SIR[s]); end
      n_vec++;
      if (out_valid !== SOV[s]) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want %b", s, out_valid, SOV[s]); end
      if (SOI[s] >= 0) begin
        n_vec++;
        if ({c_out, ovf, sum} !== SE[SOI[s]]) begin
          n_err++; $display("FAIL stall_result[%0d]: got %h want %h", s, {c_out, ovf, sum}, SE[SOI[s]]);
        end
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b1;
    a = SA[0]; b = SB[0]; c_in = SC[0]; in_valid = 1'b1;
    tick();
    a = SA[1]; b = SB[1]; c_in = SC[1];
    tick();
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL flush_pre_valid: got %b want 1", out_valid); end
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
    n_vec++;
    if (sum !== 16'h0000) begin n_err++; $display("FAIL flush_sum: got %h want 0000", sum); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stale[%0d]: out_valid got %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_add("wrap",      16'hFFFF, 16'h0001, 1'b0, 18'h20000);
    test_add("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 18'h18000);
    test_add("cin",       16'h1234, 16'h0FCB, 1'b1, 18'h02200);
    test_add("ovf_neg",   16'h8000, 16'h8000, 1'b0, 18'h30000);
    test_add("slice_cy",  16'h00FF, 16'h0001, 1'b0, 18'h00100);
    test_back_to_back();
    test_stall();
    test_reset_flush();
`ifdef PIPE_CLA_SUB_EN
    sub = 1'b1;
    test_add("sub_neg",   16'h0005, 16'h0007, 1'b1, 18'h0FFFE);
    test_add("sub_ovf",   16'h8000, 16'h0001, 1'b0, 18'h37FFF);
    sub = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
